// File: rtl/axi_pkg.sv
// Shared AXI4 constants, response/size codes and the rw bridge FSM state type.
// Used by axi_rw_bridge and axi_lane_align.
package axi_pkg;

  localparam int         AXI_ID_WIDTH   = 4;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } axi_size_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_RESP    = 3'd5
  } rw_state_e;

  // Byte-enable pattern for an access of the given size starting at lane 0.
  function automatic logic [7:0] size_strb(input logic [1:0] size);
    logic [7:0] strb;
    strb = 8'h00;
    case (size)
      SZ_B:    strb = 8'h01;
      SZ_H:    strb = 8'h03;
      SZ_W:    strb = 8'h0F;
      default: strb = 8'hFF;
    endcase
    return strb;
  endfunction

  // Bit mask keeping only the bytes covered by an access of the given size.
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] mask;
    mask = '0;
    for (int b = 0; b < 8; b++) begin
      mask[8*b +: 8] = {8{size_strb(size)[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/axi_lane_align.sv
// Combinational byte-lane alignment between a 64-bit AXI data bus and
// LSB-justified request data: store strobes/data and load extraction.
module axi_lane_align
  import axi_pkg::*;
(
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata_lane,
  output logic [63:0] rdata_ext
);

  logic [5:0] bit_off;

  assign bit_off = {offset, 3'b000};

  // Bytes pushed past lane 7 by the shift are simply dropped.
  assign wstrb      = size_strb(size) << offset;
  assign wdata_lane = wdata << bit_off;
  assign rdata_ext  = (rdata >> bit_off) & size_mask(size);

endmodule

// File: rtl/axi_rw_bridge.sv
// Single-outstanding bridge from the arbiter's rw request port to single-beat
// AXI4 reads/writes. Define AXI_RESP_CHECK_EN to report non-OKAY responses on rw_err_o.
module axi_rw_bridge
  import axi_pkg::*;
#(
  parameter int ID_W   = AXI_ID_WIDTH,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  // rw request port
  input  logic              rw_valid_i,
  output logic              rw_ready_o,
  input  logic              rw_write_i,
  input  logic [ADDR_W-1:0] rw_addr_i,
  input  logic [1:0]        rw_size_i,
  input  logic [ID_W-1:0]   rw_id_i,
  input  logic [DATA_W-1:0] rw_wdata_i,
  output logic [ID_W-1:0]   ret_id_o,
  output logic [DATA_W-1:0] ret_rdata_o,
  output logic              rw_err_o,
  // AXI write address
  output logic              aw_valid_o,
  input  logic              aw_ready_i,
  output logic [ADDR_W-1:0] aw_addr_o,
  output logic [ID_W-1:0]   aw_id_o,
  output logic [7:0]        aw_len_o,
  output logic [2:0]        aw_size_o,
  output logic [1:0]        aw_burst_o,
  // AXI write data
  output logic              w_valid_o,
  input  logic              w_ready_i,
  output logic [DATA_W-1:0] w_data_o,
  output logic [7:0]        w_strb_o,
  output logic              w_last_o,
  // AXI write response
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [ID_W-1:0]   b_id_i,
  input  logic [1:0]        b_resp_i,
  // AXI read address
  output logic              ar_valid_o,
  input  logic              ar_ready_i,
  output logic [ADDR_W-1:0] ar_addr_o,
  output logic [ID_W-1:0]   ar_id_o,
  output logic [7:0]        ar_len_o,
  output logic [2:0]        ar_size_o,
  output logic [1:0]        ar_burst_o,
  // AXI read data
  input  logic              r_valid_i,
  output logic              r_ready_o,
  input  logic [ID_W-1:0]   r_id_i,
  input  logic [1:0]        r_resp_i,
  input  logic              r_last_i,
  input  logic [DATA_W-1:0] r_data_i,
  // debug
  output logic [2:0]        dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and each valid stays asserted
  // until its own transfer. rw_ready_o is a one-cycle completion pulse.

  rw_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  axi_size_e         size_q;
  logic [ID_W-1:0]   id_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ret_rdata_q;
  logic              aw_done_q, w_done_q;
  logic              aw_fire, w_fire, rd_done, wr_done;
  logic [7:0]        wstrb;
  logic [63:0]       wdata_lane, rdata_ext;

  axi_lane_align u_align (
    .offset     (addr_q[2:0]),
    .size       (size_q),
    .wdata      (wdata_q),
    .rdata      (r_data_i),
    .wstrb      (wstrb),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  assign aw_fire = aw_valid_o && aw_ready_i;
  assign w_fire  = w_valid_o && w_ready_i;
  assign rd_done = (state_q == ST_RD_DATA) && r_valid_i && r_last_i;
  assign wr_done = (state_q == ST_WR_RESP) && b_valid_i;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (rw_valid_i) state_d = rw_write_i ? ST_WR_REQ : ST_RD_ADDR;
      ST_RD_ADDR: if (ar_ready_i) state_d = ST_RD_DATA;
      ST_RD_DATA: if (r_valid_i && r_last_i) state_d = ST_RESP;
      ST_WR_REQ:  if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = ST_WR_RESP;
      ST_WR_RESP: if (b_valid_i) state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      size_q      <= SZ_B;
      id_q        <= '0;
      wdata_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      ret_rdata_q <= '0;
    end else begin
      if (state_q == ST_IDLE && rw_valid_i) begin
        addr_q    <= rw_addr_i;
        size_q    <= axi_size_e'(rw_size_i);
        id_q      <= rw_id_i;
        wdata_q   <= rw_wdata_i;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_fire) aw_done_q <= 1'b1;
      if (w_fire)  w_done_q  <= 1'b1;
      if (rd_done) ret_rdata_q <= rdata_ext;
    end
  end

`ifdef AXI_RESP_CHECK_EN
  logic err_q;

  // Cleared on each new request so a stale error never leaks into the next pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (state_q == ST_IDLE && rw_valid_i) begin
      err_q <= 1'b0;
    end else if (rd_done) begin
      err_q <= (r_resp_i != OKAY);
    end else if (wr_done) begin
      err_q <= (b_resp_i != OKAY);
    end
  end

  assign rw_err_o = (state_q == ST_RESP) && err_q;

  logic unused_ids;
  assign unused_ids = ^{r_id_i, b_id_i};
`else
  assign rw_err_o = 1'b0;

  logic unused_ids;
  assign unused_ids = ^{r_id_i, b_id_i, r_resp_i, b_resp_i};
`endif

  assign ar_valid_o = (state_q == ST_RD_ADDR);
  assign aw_valid_o = (state_q == ST_WR_REQ) && !aw_done_q;
  assign w_valid_o  = (state_q == ST_WR_REQ) && !w_done_q;
  assign r_ready_o  = (state_q == ST_RD_DATA);
  assign b_ready_o  = (state_q == ST_WR_RESP);
  assign rw_ready_o = (state_q == ST_RESP);

  assign ret_id_o    = (state_q == ST_RESP) ? id_q : '0;
  assign ret_rdata_o = ret_rdata_q;

  assign ar_addr_o  = addr_q;
  assign ar_id_o    = id_q;
  assign ar_len_o   = 8'd0;
  assign ar_size_o  = {1'b0, size_q};
  assign ar_burst_o = AXI_BURST_INCR;

  assign aw_addr_o  = addr_q;
  assign aw_id_o    = id_q;
  assign aw_len_o   = 8'd0;
  assign aw_size_o  = {1'b0, size_q};
  assign aw_burst_o = AXI_BURST_INCR;

  assign w_data_o = wdata_lane;
  assign w_strb_o = wstrb;
  assign w_last_o = 1'b1;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi_rw_bridge.sv
// Self-checking bench for axi_rw_bridge: directed scenarios plus randomized
// traffic against a byte-level reference model. Honors AXI_RESP_CHECK_EN.
module tb_axi_rw_bridge;
  import axi_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rw_valid_i = 1'b0, rw_write_i = 1'b0;
  logic [63:0] rw_addr_i = '0, rw_wdata_i = '0;
  logic [1:0]  rw_size_i = '0;
  logic [3:0]  rw_id_i = '0;
  logic        rw_ready_o, rw_err_o;
  logic [3:0]  ret_id_o;
  logic [63:0] ret_rdata_o;
  logic        aw_valid_o, aw_ready_i = 1'b0;
  logic [63:0] aw_addr_o, ar_addr_o;
  logic [3:0]  aw_id_o, ar_id_o;
  logic [7:0]  aw_len_o, ar_len_o;
  logic [2:0]  aw_size_o, ar_size_o;
  logic [1:0]  aw_burst_o, ar_burst_o;
  logic        w_valid_o, w_ready_i = 1'b0, w_last_o;
  logic [63:0] w_data_o;
  logic [7:0]  w_strb_o;
  logic        b_valid_i = 1'b0, b_ready_o;
  logic [3:0]  b_id_i = '0, r_id_i = '0;
  logic [1:0]  b_resp_i = '0, r_resp_i = '0;
  logic        ar_valid_o, ar_ready_i = 1'b0;
  logic        r_valid_i = 1'b0, r_ready_o, r_last_i = 1'b0;
  logic [63:0] r_data_i = '0;
  logic [2:0]  dbg_state;

  axi_rw_bridge dut (
    .clock(clock), .reset(reset),
    .rw_valid_i(rw_valid_i), .rw_ready_o(rw_ready_o), .rw_write_i(rw_write_i),
    .rw_addr_i(rw_addr_i), .rw_size_i(rw_size_i), .rw_id_i(rw_id_i), .rw_wdata_i(rw_wdata_i),
    .ret_id_o(ret_id_o), .ret_rdata_o(ret_rdata_o), .rw_err_o(rw_err_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_id_o(aw_id_o),
    .aw_len_o(aw_len_o), .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
    .w_last_o(w_last_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_id_i(b_id_i), .b_resp_i(b_resp_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_id_o(ar_id_o),
    .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_id_i(r_id_i), .r_resp_i(r_resp_i),
    .r_last_i(r_last_i), .r_data_i(r_data_i),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_rdata = '0;

  typedef struct {
    int          lat;
    int          n_ready;
    logic [3:0]  ret_id;
    logic [63:0] ret_rdata;
    logic        err;
    logic [63:0] ax_addr;
    logic [2:0]  ax_size;
    logic [3:0]  ax_id;
    logic [7:0]  ax_len;
    logic [1:0]  ax_burst;
    logic [7:0]  strb;
    logic [63:0] wdata;
    logic        wlast;
    bit          addr_moved;
    bit          valid_after_hs;
    bit          valid_in_latch;
  } obs_t;

  // reference model: byte-level view of an access
  function automatic int n_bytes(input logic [1:0] s);
    return 1 << s;
  endfunction

  function automatic logic [7:0] m_strb(input logic [63:0] a, input logic [1:0] s);
    logic [7:0] r;
    int off;
    r = '0;
    off = int'(a[2:0]);
    for (int b = 0; b < 8; b++) r[b] = (b >= off) && (b < off + n_bytes(s));
    return r;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] a, input logic [63:0] w);
    logic [63:0] r;
    int off;
    r = '0;
    off = int'(a[2:0]);
    for (int b = 0; b < 8; b++) if (b >= off) r[8*b +: 8] = w[8*(b-off) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_rdata(input logic [63:0] a, input logic [1:0] s, input logic [63:0] d);
    logic [63:0] r;
    int off;
    r = '0;
    off = int'(a[2:0]);
    for (int b = 0; b < n_bytes(s); b++) if (off + b < 8) r[8*b +: 8] = d[8*(off+b) +: 8];
    return r;
  endfunction

  function automatic logic m_err(input logic [1:0] resp);
`ifdef AXI_RESP_CHECK_EN
    return resp != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_lat(input bit wr, input int ar_wait, input int aw_wait, input int w_wait);
    if (wr) return 4 + ((aw_wait > w_wait) ? aw_wait : w_wait);
    return 4 + ar_wait;
  endfunction

  task automatic clear_slave();
    aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
    r_valid_i = 0; r_last_i = 0; b_valid_i = 0;
  endtask

  // driver: arbiter side plus a behavioural slave, one loop iteration per cycle
  task automatic run_txn(input bit wr, input logic [63:0] addr, input logic [1:0] size,
                         input logic [3:0] id, input logic [63:0] wdata, input logic [63:0] rdata,
                         input int ar_wait, input int aw_wait, input int w_wait,
                         input logic [1:0] resp, input bit scramble, output obs_t o);
    int ar_cnt, aw_cnt, w_cnt;
    bit ar_fire, aw_fire, w_fire, r_fire, b_fire;
    bit r_pend, b_pend, aw_got, w_got, b_started, ax_seen, w_seen;
    o = '{lat: -1, default: '0};
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    {ar_fire, aw_fire, w_fire, r_fire, b_fire} = '0;
    {r_pend, b_pend, aw_got, w_got, b_started, ax_seen, w_seen} = '0;
    @(negedge clock);
    rw_valid_i = 1; rw_write_i = wr; rw_addr_i = addr; rw_size_i = size;
    rw_id_i = id; rw_wdata_i = wdata;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc > 1) begin
        @(negedge clock);
        if (ar_fire) r_pend = 1;
        if (r_fire) r_pend = 0;
        if (aw_fire) aw_got = 1;
        if (w_fire) w_got = 1;
        if (b_fire) b_pend = 0;
        if (aw_got && w_got && !b_started) begin b_pend = 1; b_started = 1; end
        if (scramble) begin
          rw_addr_i = {$urandom, $urandom}; rw_size_i = 2'($urandom);
          rw_id_i = 4'($urandom); rw_write_i = ~wr; rw_wdata_i = {$urandom, $urandom};
        end
      end
      if (rw_ready_o) begin
        o.lat = cyc; o.n_ready = 1; o.ret_id = ret_id_o;
        o.ret_rdata = ret_rdata_o; o.err = rw_err_o;
        break;
      end
      if (cyc == 1) o.valid_in_latch = ar_valid_o | aw_valid_o | w_valid_o;
      if (ar_valid_o || aw_valid_o) begin
        if (!ax_seen) begin
          ax_seen = 1;
          o.ax_addr  = ar_valid_o ? ar_addr_o  : aw_addr_o;
          o.ax_size  = ar_valid_o ? ar_size_o  : aw_size_o;
          o.ax_id    = ar_valid_o ? ar_id_o    : aw_id_o;
          o.ax_len   = ar_valid_o ? ar_len_o   : aw_len_o;
          o.ax_burst = ar_valid_o ? ar_burst_o : aw_burst_o;
        end
        if ((ar_valid_o ? ar_addr_o : aw_addr_o) !== addr) o.addr_moved = 1;
      end
      if (w_valid_o && !w_seen) begin
        w_seen = 1; o.strb = w_strb_o; o.wdata = w_data_o; o.wlast = w_last_o;
      end
      if ((aw_valid_o && aw_got) || (w_valid_o && w_got)) o.valid_after_hs = 1;
      ar_ready_i = ar_valid_o && (ar_cnt >= ar_wait);
      aw_ready_i = aw_valid_o && (aw_cnt >= aw_wait);
      w_ready_i  = w_valid_o && (w_cnt >= w_wait);
      if (ar_valid_o) ar_cnt++;
      if (aw_valid_o) aw_cnt++;
      if (w_valid_o) w_cnt++;
      r_valid_i = r_pend; r_last_i = r_pend; r_data_i = rdata; r_resp_i = resp; r_id_i = ~id;
      b_valid_i = b_pend; b_resp_i = resp; b_id_i = ~id;
      ar_fire = ar_valid_o && ar_ready_i;
      aw_fire = aw_valid_o && aw_ready_i;
      w_fire  = w_valid_o && w_ready_i;
      r_fire  = r_valid_i && r_ready_o;
      b_fire  = b_valid_i && b_ready_o;
    end
    rw_valid_i = 0;
    clear_slave();
    if (o.lat < 0) begin
      reset = 0;
      @(negedge clock);
      reset = 1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        @(negedge clock);
        if (rw_ready_o) o.n_ready++;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({ar_valid_o, aw_valid_o, w_valid_o, r_ready_o, b_ready_o, rw_ready_o, rw_err_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {ar_valid_o, aw_valid_o, w_valid_o, r_ready_o, b_ready_o, rw_ready_o, rw_err_o});
    end
    checks++;
    if (ret_id_o !== 4'd0) begin errors++; $display("FAIL reset_ret_id: got %0h expected 0", ret_id_o); end
    checks++;
    if (ret_rdata_o !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %0h expected 0", ret_rdata_o); end
    reset = 1;
  endtask

  task automatic test_read_dword();
    obs_t o;
    run_txn(0, 64'h8000_0000, 2'd3, 4'd1, '0, 64'h1122_3344_5566_7788, 0, 0, 0, 2'b00, 0, o);
    checks++;
    if (o.ax_addr !== 64'h8000_0000) begin errors++; $display("FAIL rd_ar_addr: got %0h expected 80000000", o.ax_addr); end
    checks++;
    if ({o.ax_size, o.ax_len, o.ax_burst, o.ax_id} !== {3'd3, 8'd0, 2'b01, 4'd1}) begin
      errors++;
      $display("FAIL rd_ar_attr: got size %0d len %0d burst %0d id %0d expected 3 0 1 1", o.ax_size, o.ax_len, o.ax_burst, o.ax_id);
    end
    checks++;
    if (o.valid_in_latch !== 1'b0) begin errors++; $display("FAIL rd_latch_valid: got %b expected 0", o.valid_in_latch); end
    checks++;
    if (o.lat !== 4) begin errors++; $display("FAIL rd_latency: got %0d expected 4", o.lat); end
    checks++;
    if (o.ret_id !== 4'd1) begin errors++; $display("FAIL rd_ret_id: got %0d expected 1", o.ret_id); end
    checks++;
    if (o.ret_rdata !== 64'h1122_3344_5566_7788) begin
      errors++; $display("FAIL rd_dword_data: got %0h expected 1122334455667788", o.ret_rdata);
    end
    checks++;
    if (o.n_ready !== 1) begin errors++; $display("FAIL rd_pulse_count: got %0d expected 1", o.n_ready); end
    last_rdata = 64'h1122_3344_5566_7788;
  endtask

  task automatic test_read_byte();
    obs_t o;
    run_txn(0, 64'h8000_0005, 2'd0, 4'd1, '0, 64'h1122_3344_5566_7788, 0, 0, 0, 2'b00, 0, o);
    checks++;
    if (o.ret_rdata !== 64'h33) begin errors++; $display("FAIL rd_byte_data: got %0h expected 33", o.ret_rdata); end
    checks++;
    if (o.ax_size !== 3'd0) begin errors++; $display("FAIL rd_byte_size: got %0d expected 0", o.ax_size); end
    last_rdata = 64'h33;
  endtask

  task automatic test_store_half();
    obs_t o;
    run_txn(1, 64'h8000_0006, 2'd1, 4'd2, 64'hBEEF, '0, 0, 0, 2, 2'b00, 0, o);
    checks++;
    if (o.strb !== 8'hC0) begin errors++; $display("FAIL st_strb: got %0h expected c0", o.strb); end
    checks++;
    if (o.wdata[63:48] !== 16'hBEEF) begin errors++; $display("FAIL st_wdata: got %0h expected beef", o.wdata[63:48]); end
    checks++;
    if (o.wlast !== 1'b1) begin errors++; $display("FAIL st_wlast: got %b expected 1", o.wlast); end
    checks++;
    if (o.valid_after_hs !== 1'b0) begin errors++; $display("FAIL st_aw_drop: got %b expected 0", o.valid_after_hs); end
    checks++;
    if (o.lat !== 6) begin errors++; $display("FAIL st_latency: got %0d expected 6", o.lat); end
    checks++;
    if (o.ret_id !== 4'd2 || o.n_ready !== 1) begin
      errors++; $display("FAIL st_completion: got id %0d pulses %0d expected id 2 pulses 1", o.ret_id, o.n_ready);
    end
    checks++;
    if (o.ret_rdata !== last_rdata) begin errors++; $display("FAIL st_rdata_kept: got %0h expected %0h", o.ret_rdata, last_rdata); end
  endtask

  task automatic test_ar_stall();
    obs_t o;
    logic [63:0] d;
    d = {$urandom, $urandom};
    run_txn(0, 64'h8000_0100, 2'd2, 4'd1, '0, d, 5, 0, 0, 2'b00, 1, o);
    checks++;
    if (o.addr_moved !== 1'b0) begin errors++; $display("FAIL stall_addr_held: got %b expected 0", o.addr_moved); end
    checks++;
    if (o.lat !== 9) begin errors++; $display("FAIL stall_latency: got %0d expected 9", o.lat); end
    checks++;
    if (o.ret_rdata !== m_rdata(64'h8000_0100, 2'd2, d) || o.ret_id !== 4'd1) begin
      errors++; $display("FAIL stall_result: got %0h/%0d expected %0h/1", o.ret_rdata, o.ret_id, m_rdata(64'h8000_0100, 2'd2, d));
    end
    last_rdata = m_rdata(64'h8000_0100, 2'd2, d);
  endtask

  task automatic test_reset_mid();
    obs_t o;
    @(negedge clock);
    rw_valid_i = 1; rw_write_i = 0; rw_addr_i = 64'h8000_0010; rw_size_i = 2'd3; rw_id_i = 4'd1;
    @(negedge clock);
    ar_ready_i = ar_valid_o;
    @(negedge clock);
    ar_ready_i = 0;
    checks++;
    if (r_ready_o !== 1'b1) begin errors++; $display("FAIL mid_in_rd_data: got %b expected 1", r_ready_o); end
    @(posedge clock);
    #2 reset = 0;
    rw_valid_i = 0;
    #1;
    checks++;
    if ({ar_valid_o, aw_valid_o, w_valid_o, r_ready_o, b_ready_o, rw_ready_o} !== 6'b0) begin
      errors++; $display("FAIL mid_reset_ctrl: got %b expected 000000",
                         {ar_valid_o, aw_valid_o, w_valid_o, r_ready_o, b_ready_o, rw_ready_o});
    end
    checks++;
    if (ret_rdata_o !== 64'd0) begin errors++; $display("FAIL mid_reset_rdata: got %0h expected 0", ret_rdata_o); end
    @(negedge clock);
    reset = 1;
    run_txn(0, 64'h8000_0008, 2'd3, 4'd1, '0, 64'hCAFE_F00D_DEAD_BEEF, 0, 0, 0, 2'b00, 0, o);
    checks++;
    if (o.lat !== 4 || o.ret_rdata !== 64'hCAFE_F00D_DEAD_BEEF) begin
      errors++; $display("FAIL mid_recover: got lat %0d data %0h expected 4 cafef00ddeadbeef", o.lat, o.ret_rdata);
    end
    last_rdata = 64'hCAFE_F00D_DEAD_BEEF;
  endtask

  task automatic test_resp_err();
    obs_t o;
    run_txn(1, 64'h8000_0020, 2'd3, 4'd2, 64'h1234, '0, 0, 1, 0, 2'b10, 0, o);
    checks++;
    if (o.err !== m_err(2'b10)) begin errors++; $display("FAIL err_b_slverr: got %b expected %b", o.err, m_err(2'b10)); end
    run_txn(0, 64'h8000_0021, 2'd0, 4'd1, '0, 64'hA5A5, 0, 0, 0, 2'b11, 0, o);
    checks++;
    if (o.err !== m_err(2'b11) || o.ret_rdata !== 64'hA5) begin
      errors++; $display("FAIL err_r_decerr: got err %b data %0h expected %b a5", o.err, o.ret_rdata, m_err(2'b11));
    end
    last_rdata = 64'hA5;
    run_txn(0, 64'h8000_0028, 2'd3, 4'd1, '0, 64'h77, 0, 0, 0, 2'b00, 0, o);
    checks++;
    if (o.err !== 1'b0) begin errors++; $display("FAIL err_okay_clear: got %b expected 0", o.err); end
    last_rdata = 64'h77;
  endtask

  task automatic test_random();
    obs_t o;
    for (int n = 0; n < 24; n++) begin
      bit          wr;
      logic [63:0] addr, wd, rd, exp_d;
      logic [1:0]  sz, resp;
      logic [3:0]  id;
      int          arw, aww, ww;
      wr = 1'($urandom); addr = 64'h8000_0000 + 64'($urandom_range(0, 1023));
      sz = 2'($urandom_range(0, 3)); id = 4'($urandom_range(1, 2));
      wd = {$urandom, $urandom}; rd = {$urandom, $urandom}; resp = 2'($urandom_range(0, 3));
      arw = $urandom_range(0, 3); aww = $urandom_range(0, 3); ww = $urandom_range(0, 3);
      if (!wr) exp_q.push_back(m_rdata(addr, sz, rd));
      run_txn(wr, addr, sz, id, wd, rd, arw, aww, ww, resp, 1, o);
      exp_d = wr ? last_rdata : exp_q.pop_front();
      checks++;
      if (o.lat !== m_lat(wr, arw, aww, ww) || o.n_ready !== 1) begin
        errors++; $display("FAIL rnd_timing[%0d]: got lat %0d pulses %0d expected %0d 1", n, o.lat, o.n_ready, m_lat(wr, arw, aww, ww));
      end
      checks++;
      if (o.ret_id !== id || o.err !== m_err(resp)) begin
        errors++; $display("FAIL rnd_id_err[%0d]: got %0d/%b expected %0d/%b", n, o.ret_id, o.err, id, m_err(resp));
      end
      checks++;
      if (o.ret_rdata !== exp_d) begin errors++; $display("FAIL rnd_rdata[%0d]: got %0h expected %0h", n, o.ret_rdata, exp_d); end
      checks++;
      if (o.ax_addr !== addr || o.ax_size !== {1'b0, sz} || o.addr_moved) begin
        errors++; $display("FAIL rnd_addr[%0d]: got %0h size %0d expected %0h size %0d", n, o.ax_addr, o.ax_size, addr, sz);
      end
      if (wr) begin
        checks++;
        if (o.strb !== m_strb(addr, sz) || o.wdata !== m_wdata(addr, wd) || o.valid_after_hs) begin
          errors++; $display("FAIL rnd_wbeat[%0d]: got %0h/%0h expected %0h/%0h", n, o.strb, o.wdata, m_strb(addr, sz), m_wdata(addr, wd));
        end
      end
      last_rdata = exp_d;
    end
  endtask

  initial begin
    test_reset();
    test_read_dword();
    test_read_byte();
    test_store_half();
    test_ar_stall();
    test_reset_mid();
    test_resp_err();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_rw_bridge.md
Name: axi_rw_bridge

Overview:
- Responder for the simplified rw request interface driven by the IF/MEM arbiter, and initiator on the core's AXI4 master port.
- Accepts one request at a time: valid/addr/size/id/write/wdata.
- Issues a single-beat AXI4 read (AR/R) or write (AW/W/B) transaction.
- Returns ret_id, aligned read data and a one-cycle completion pulse on rw_ready_o.

Parameters:
ID_W, 4 (`AXI_ID_WIDTH`), AXI and rw id width
DATA_W, 64, AXI data bus width; only 64 supported
ADDR_W, 64, address width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset (0 = reset)
rw_valid_i  in  1  request valid; held by arbiter until rw_ready_o
rw_ready_o  out  1  completion pulse, one cycle
rw_write_i  in  1  1=store, 0=load
rw_addr_i  in  ADDR_W  byte address
rw_size_i  in  2  0=byte,1=half,2=word,3=dword
rw_id_i  in  ID_W  requester id (1=IF, 2=MEM)
rw_wdata_i  in  64  store data, LSB-justified
ret_id_o  out  ID_W  id of completed request
ret_rdata_o  out  64  load data, LSB-justified, zero-extended
rw_err_o  out  1  error flag qualified by rw_ready_o (see Optional Feature)
aw_valid_o / ar_valid_o  out  1  address valid
aw_ready_i / ar_ready_i  in  1  address ready
aw_addr_o / ar_addr_o  out  ADDR_W  latched request address
aw_id_o / ar_id_o  out  ID_W  latched request id
aw_len_o / ar_len_o  out  8  constant 0 (single beat)
aw_size_o / ar_size_o  out  3  {1'b0, latched size}
aw_burst_o / ar_burst_o  out  2  constant INCR (2'b01)
w_valid_o  out  1  write data valid
w_ready_i  in  1  write data ready
w_data_o  out  64  store data shifted to byte lane addr[2:0]
w_strb_o  out  8  size mask << addr[2:0]
w_last_o  out  1  constant 1
b_valid_i / b_ready_o  in / out  1  write response handshake
b_id_i / b_resp_i  in  ID_W / 2  write response id, resp
r_valid_i / r_ready_o  in / out  1  read data handshake
r_id_i / r_resp_i / r_last_i  in  ID_W / 2 / 1  read id, resp, last
r_data_i  in  64  read data

Behaviour:
- Reset (async assert, sync deassert external): state=IDLE; all *_valid_o, r_ready_o, b_ready_o, rw_ready_o, rw_err_o = 0; ret_id_o=0; ret_rdata_o=0; latched request cleared.
- FSM states:
  - IDLE: on rw_valid_i=1, latch addr/size/id/write/wdata. Go to WR_REQ if write, else RD_ADDR. No AXI valid asserted in the latch cycle.
  - RD_ADDR: ar_valid_o=1; on ar_ready_i go to RD_DATA.
  - RD_DATA: r_ready_o=1; on r_valid_i & r_last_i, capture ret_rdata_o = mask_size(r_data_i >> 8*addr[2:0]) and go to RESP.
  - WR_REQ: aw_valid_o and w_valid_o both asserted. Separate aw_done/w_done flags; each valid drops after its own handshake. Same-cycle aw_ready_i & w_ready_i completes both. When both are done, go to WR_RESP.
  - WR_RESP: b_ready_o=1; on b_valid_i go to RESP.
  - RESP: rw_ready_o=1 and ret_id_o=latched id for exactly one cycle, then IDLE.
- Minimum latency with zero-wait slave:
  - read: accept -> ar -> r -> RESP = rw_ready_o 4 cycles after the rw_valid_i sample.
  - write: 4 cycles.
- rw_valid_i still high in the IDLE cycle after RESP starts a new request. The arbiter must deassert or re-target by then.
- Data and id:
  - ret_rdata_o holds until the next read completes.
  - Writes do not modify ret_rdata_o.
  - ret_id_o is the latched id; r_id_i/b_id_i are ignored for routing.
- Alignment:
  - w_strb_o: size 0/1/2/3 gives 8'h01/03/0F/FF, shifted left by addr[2:0].
  - w_data_o: rw_wdata_i << 8*addr[2:0].
  - A request crossing an 8-byte boundary is unsupported; upper bytes are truncated by the shift and no error is raised.
- Input changes on rw_* after the latch cycle are ignored.
- Reset mid-transaction abandons it immediately; the slave must be reset together with this block.

Optional Feature:
- Macro: AXI_RESP_CHECK_EN.
- Defined: rw_err_o = 1 together with rw_ready_o when the captured r_resp_i or b_resp_i != OKAY (2'b00). Data is still returned.
- Undefined: rw_err_o is constant 0 and resp inputs are unused.

Decomposition:
- Package axi_pkg:
  - AXI_ID_WIDTH
  - AXI_BURST_INCR
  - resp codes OKAY/EXOKAY/SLVERR/DECERR
  - size enum (SZ_B/SZ_H/SZ_W/SZ_D)
  - FSM state enum
- Sub-module axi_lane_align (combinational):
  - inputs: addr[2:0], size, wdata, rdata
  - outputs: wstrb, shifted wdata, extracted rdata
  - reusable by a future cache refill path.

Test Plan:
- Read dword, addr 0x8000_0000, id 1; slave returns 0x1122334455667788 with zero wait -> ar_addr 0x80000000, ar_size 3, rw_ready_o 4 cycles later, ret_id 1, ret_rdata 0x1122334455667788.
- Read byte, addr 0x8000_0005, r_data 0x1122334455667788 -> ret_rdata 0x0000000000000033.
- Store half, addr 0x8000_0006, wdata 0xBEEF; aw_ready 2 cycles before w_ready -> w_strb 0xC0, w_data[63:48]=0xBEEF, aw_valid drops after its own handshake, one rw_ready_o, id 2.
- Slave holds ar_ready=0 for 5 cycles while rw_addr_i changes -> ar_addr stays at the latched value; completion delayed by exactly 5 cycles.
- Assert reset low in RD_DATA -> all valids/readies 0 immediately, ret_rdata 0; after release, a new read completes normally.
- AXI_RESP_CHECK_EN defined, b_resp=SLVERR -> rw_err_o=1 in the rw_ready_o cycle. Macro undefined -> rw_err_o=0.
